// File: rtl/voting_machine_multi.sv
// voting_machine_multi: N-candidate debounced voting machine with saturating
// tallies, result-display mode and live winner/tie outputs.
module voting_machine_multi #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEBOUNCE = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mode,
  input  logic [NUM_CAND-1:0]           button,
  output logic [CNT_W-1:0]              led,
  output logic                          vote_valid,
  output logic [$clog2(NUM_CAND)-1:0]   winner,
  output logic                          tie
);

  localparam int unsigned IDX_W = $clog2(NUM_CAND);
  localparam int unsigned DBC_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] TALLY_MAX = '1;
  localparam logic [DBC_W-1:0] DBC_LAST  = DBC_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [DBC_W-1:0]   cnt_q, cnt_d;
  logic               disp_hold_q, disp_hold_d;
  logic [CNT_W-1:0]   tally_q [NUM_CAND];
  logic [CNT_W-1:0]   tally_d [NUM_CAND];
  logic [CNT_W-1:0]   led_q, led_d;
  logic               vote_valid_q, vote_valid_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               tie_q, tie_d;

  logic               any_c;
  logic               multi_c;
  logic               single_c;
  logic [IDX_W-1:0]   low_idx_c;
  logic               vote_c;
  logic [CNT_W-1:0]   best_c;
  logic               seen_c;
  logic               dup_c;

  // Button-set decode: any/multiple/single high and lowest high index
  always_comb begin
    any_c     = |button;
    multi_c   = |(button & (button - NUM_CAND'(1)));
    single_c  = any_c & ~multi_c;
    low_idx_c = '0;
    for (int i = int'(NUM_CAND) - 1; i >= 0; i--) begin
      if (button[i]) low_idx_c = IDX_W'(i);
    end
  end

  // Remember a press that started in display mode so it cannot vote later
  always_comb begin
    disp_hold_d = any_c & (mode | disp_hold_q);
  end

  // FSM next-state, debounce counter and vote strobe
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    vote_c  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!mode && any_c) begin
          if (disp_hold_q || multi_c) begin
            state_d = WAIT_REL;
          end else begin
            state_d = ARMED;
            sel_d   = low_idx_c;
            cnt_d   = DBC_W'(1);
          end
        end
      end
      ARMED: begin
        if (mode || !single_c || (low_idx_c != sel_q)) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == DBC_LAST) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
          vote_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + DBC_W'(1);
        end
      end
      WAIT_REL: begin
        cnt_d = '0;
        if (!any_c) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating tally update
  always_comb begin
    tally_d = tally_q;
    if (vote_c && (tally_q[sel_q] != TALLY_MAX)) begin
      tally_d[sel_q] = tally_q[sel_q] + CNT_W'(1);
    end
  end

  // Display value and vote pulse
  always_comb begin
    led_d        = '0;
    vote_valid_d = vote_c;
    if (mode && any_c) led_d = tally_q[low_idx_c];
  end

  // Winner (lowest index on equal maxima) and tie detection
  always_comb begin
    best_c   = '0;
    winner_d = '0;
    seen_c   = 1'b0;
    dup_c    = 1'b0;
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (tally_q[i] > best_c) begin
        best_c   = tally_q[i];
        winner_d = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (tally_q[i] == best_c) begin
        if (seen_c) dup_c = 1'b1;
        seen_c = 1'b1;
      end
    end
    tie_d = dup_c & (best_c != '0);
  end

  // FSM and debounce state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      disp_hold_q <= disp_hold_d;
    end
  end

  // Tally registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tally_q <= '{default: '0};
    end else begin
      tally_q <= tally_d;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q        <= '0;
      vote_valid_q <= 1'b0;
      winner_q     <= '0;
      tie_q        <= 1'b0;
    end else begin
      led_q        <= led_d;
      vote_valid_q <= vote_valid_d;
      winner_q     <= winner_d;
      tie_q        <= tie_d;
    end
  end

  assign led        = led_q;
  assign vote_valid = vote_valid_q;
  assign winner     = winner_q;
  assign tie        = tie_q;

endmodule

// File: tb/tb_voting_machine_multi.sv
// Testbench for voting_machine_multi: a default instance and a CNT_W=2
// instance share the same stimulus and are checked against a press-level model.
module tb_voting_machine_multi;

  localparam int DEB = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] button;

  logic [7:0] led;
  logic       vv;
  logic [1:0] winner;
  logic       tie;
  logic [1:0] led_s;
  logic       vv_s;
  logic [1:0] winner_s;
  logic       tie_s;

  int checks = 0;
  int errors = 0;
  int m_tally[4];
  int s_tally[4];

  always #5 clock = ~clock;

  voting_machine_multi #(.NUM_CAND(4), .CNT_W(8), .DEBOUNCE(DEB)) dut (
    .clock(clock), .reset(reset), .mode(mode), .button(button),
    .led(led), .vote_valid(vv), .winner(winner), .tie(tie)
  );

  voting_machine_multi #(.NUM_CAND(4), .CNT_W(2), .DEBOUNCE(DEB)) dut_sat (
    .clock(clock), .reset(reset), .mode(mode), .button(button),
    .led(led_s), .vote_valid(vv_s), .winner(winner_s), .tie(tie_s)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit is_single(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

  function automatic int idx_of(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction

  // Highest tally, lowest index wins; tie when the nonzero max is shared
  function automatic void model_result(input int t[4], output int w, output bit ti);
    int best = 0;
    int n = 0;
    w = 0;
    for (int i = 0; i < 4; i++) if (t[i] > best) begin best = t[i]; w = i; end
    for (int i = 0; i < 4; i++) if (t[i] == best) n++;
    ti = (best > 0) && (n >= 2);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin m_tally[i] = 0; s_tally[i] = 0; end
  endfunction

  // Hold b for `hold` cycles then release for `gap` cycles; toggle mode at sw_at
  task automatic press(input logic [3:0] b, input int hold, input int gap, input int sw_at,
                       output bit exp_v, output int np_m, output int np_s,
                       output int at_m, output int at_s);
    int k;
    exp_v = (mode == 1'b0) && is_single(b) && (hold >= DEB) && (sw_at == 0 || sw_at >= DEB);
    np_m = 0; np_s = 0; at_m = 0; at_s = 0;
    @(negedge clock);
    button = b;
    for (int i = 1; i <= hold + gap; i++) begin
      @(negedge clock);
      if (vv === 1'b1) begin np_m++; if (at_m == 0) at_m = i; end
      if (vv_s === 1'b1) begin np_s++; if (at_s == 0) at_s = i; end
      if (i == sw_at) mode = ~mode;
      if (i == hold) button = 4'd0;
    end
    if (exp_v) begin
      k = idx_of(b);
      m_tally[k] = (m_tally[k] < 255) ? m_tally[k] + 1 : 255;
      s_tally[k] = (s_tally[k] < 3) ? s_tally[k] + 1 : 3;
    end
  endtask

  task automatic read_led(input int c, output logic [7:0] lm, output logic [1:0] ls);
    @(negedge clock);
    mode = 1'b1;
    button = 4'(1 << c);
    @(negedge clock);
    lm = led;
    ls = led_s;
    button = 4'd0;
    mode = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    int np;
    logic [7:0] lm;
    logic [1:0] ls;
    reset = 1'b0; mode = 1'b0; button = 4'd0;
    model_clear();
    repeat (10) @(negedge clock);
    checks++;
    if (led !== 8'd0 || vv !== 1'b0 || winner !== 2'd0 || tie !== 1'b0) begin
      errors++;
      $display("FAIL reset_main: led=%0d vv=%b winner=%0d tie=%b, required all 0", led, vv, winner, tie);
    end
    checks++;
    if (led_s !== 2'd0 || vv_s !== 1'b0 || winner_s !== 2'd0 || tie_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: led=%0d vv=%b winner=%0d tie=%b, required all 0", led_s, vv_s, winner_s, tie_s);
    end
    reset = 1'b1;
    @(negedge clock);
    button = 4'b0001;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    button = 4'd0;
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    np = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (vv === 1'b1 || vv_s === 1'b1) np++;
    end
    checks++;
    if (np !== 0) begin
      errors++;
      $display("FAIL reset_mid_armed_pulse: pulses=%0d, required 0", np);
    end
    read_led(0, lm, ls);
    checks++;
    if (lm !== 8'd0 || ls !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_armed_tally: led=%0d led_s=%0d, required 0 0", lm, ls);
    end
  endtask

  task automatic test_single_vote();
    bit ev; int nm, ns, am, as_;
    logic [7:0] lm; logic [1:0] ls;
    press(4'b0001, 20, 4, 0, ev, nm, ns, am, as_);
    checks++;
    if (nm !== 1 || am !== DEB) begin
      errors++;
      $display("FAIL single_vote_main: pulses=%0d at=%0d, required 1 at %0d", nm, am, DEB);
    end
    checks++;
    if (ns !== 1 || as_ !== DEB) begin
      errors++;
      $display("FAIL single_vote_sat: pulses=%0d at=%0d, required 1 at %0d", ns, as_, DEB);
    end
    read_led(0, lm, ls);
    checks++;
    if (lm !== 8'(m_tally[0]) || ls !== 2'(s_tally[0])) begin
      errors++;
      $display("FAIL single_vote_led: led=%0d led_s=%0d, required %0d %0d", lm, ls, m_tally[0], s_tally[0]);
    end
  endtask

  task automatic test_short_press();
    bit ev; int nm, ns, am, as_;
    logic [7:0] lm; logic [1:0] ls;
    press(4'b0010, 5, 4, 0, ev, nm, ns, am, as_);
    checks++;
    if (nm !== 0 || ns !== 0) begin
      errors++;
      $display("FAIL short_press: pulses=%0d/%0d, required 0/0", nm, ns);
    end
    press(4'b0010, DEB - 1, 4, 0, ev, nm, ns, am, as_);
    checks++;
    if (nm !== 0 || ns !== 0) begin
      errors++;
      $display("FAIL press_deb_minus_1: pulses=%0d/%0d, required 0/0", nm, ns);
    end
    read_led(1, lm, ls);
    checks++;
    if (lm !== 8'd0 || ls !== 2'd0) begin
      errors++;
      $display("FAIL short_press_led: led=%0d led_s=%0d, required 0 0", lm, ls);
    end
  endtask

  task automatic test_multi_press();
    bit ev; int nm, ns, am, as_;
    logic [7:0] lm; logic [1:0] ls;
    press(4'b0110, 20, 4, 0, ev, nm, ns, am, as_);
    checks++;
    if (nm !== 0 || ns !== 0) begin
      errors++;
      $display("FAIL multi_press: pulses=%0d/%0d, required 0/0", nm, ns);
    end
    press(4'b0100, 20, 4, 0, ev, nm, ns, am, as_);
    checks++;
    if (nm !== 1 || am !== DEB || ns !== 1) begin
      errors++;
      $display("FAIL after_multi_vote: pulses=%0d at=%0d sat=%0d, required 1 at %0d", nm, am, ns, DEB);
    end
    read_led(2, lm, ls);
    checks++;
    if (lm !== 8'(m_tally[2]) || lm !== 8'd1) begin
      errors++;
      $display("FAIL tally2: led=%0d, required %0d", lm, m_tally[2]);
    end
  endtask

  task automatic test_winner_tie();
    bit ev; int nm, ns, am, as_;
    int w; bit ti;
    model_result(m_tally, w, ti);
    checks++;
    if (winner !== 2'(w) || tie !== ti) begin
      errors++;
      $display("FAIL winner_tie_1: winner=%0d tie=%b, required %0d %b", winner, tie, w, ti);
    end
    press(4'b0100, 12, 4, 0, ev, nm, ns, am, as_);
    model_result(m_tally, w, ti);
    checks++;
    if (winner !== 2'(w) || tie !== ti || w !== 2) begin
      errors++;
      $display("FAIL winner_tie_2: winner=%0d tie=%b, required %0d %b", winner, tie, w, ti);
    end
    model_result(s_tally, w, ti);
    checks++;
    if (winner_s !== 2'(w) || tie_s !== ti) begin
      errors++;
      $display("FAIL winner_tie_sat: winner=%0d tie=%b, required %0d %b", winner_s, tie_s, w, ti);
    end
  endtask

  task automatic test_mode_switch();
    bit ev; int nm, ns, am, as_;
    press(4'b0001, 20, 4, 4, ev, nm, ns, am, as_);
    mode = 1'b0;
    checks++;
    if (nm !== 0 || ns !== 0) begin
      errors++;
      $display("FAIL mode_abort_armed: pulses=%0d/%0d, required 0/0", nm, ns);
    end
    mode = 1'b1;
    press(4'b1000, 20, 4, 5, ev, nm, ns, am, as_);
    mode = 1'b0;
    checks++;
    if (nm !== 0 || ns !== 0) begin
      errors++;
      $display("FAIL display_to_vote_held: pulses=%0d/%0d, required 0/0", nm, ns);
    end
  endtask

  task automatic test_saturation();
    bit ev; int nm, ns, am, as_;
    int tot_m, tot_s;
    logic [7:0] lm; logic [1:0] ls;
    tot_m = 0; tot_s = 0;
    for (int p = 0; p < 5; p++) begin
      press(4'b1000, 12, 4, 0, ev, nm, ns, am, as_);
      tot_m += nm; tot_s += ns;
    end
    checks++;
    if (tot_m !== 5 || tot_s !== 5) begin
      errors++;
      $display("FAIL sat_pulses: pulses=%0d/%0d, required 5/5", tot_m, tot_s);
    end
    read_led(3, lm, ls);
    checks++;
    if (ls !== 2'd3 || lm !== 8'(m_tally[3])) begin
      errors++;
      $display("FAIL sat_led: led=%0d led_s=%0d, required %0d 3", lm, ls, m_tally[3]);
    end
    mode = 1'b1;
    press(4'b1000, 20, 4, 0, ev, nm, ns, am, as_);
    mode = 1'b0;
    checks++;
    if (nm !== 0 || ns !== 0) begin
      errors++;
      $display("FAIL display_press: pulses=%0d/%0d, required 0/0", nm, ns);
    end
  endtask

  task automatic test_random();
    bit ev; int nm, ns, am, as_;
    int w; bit ti; int c;
    logic [3:0] b;
    logic [7:0] lm; logic [1:0] ls;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 7) b = 4'(1 << $urandom_range(0, 3));
      else b = 4'($urandom_range(1, 15));
      press(b, int'($urandom_range(1, 16)), int'($urandom_range(3, 6)), 0, ev, nm, ns, am, as_);
      checks++;
      if (nm !== (ev ? 1 : 0) || am !== (ev ? DEB : 0) || ns !== (ev ? 1 : 0) || as_ !== (ev ? DEB : 0)) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: b=%b pulses=%0d/%0d at=%0d/%0d, required %0d", it, b, nm, ns, am, as_, ev);
      end
      model_result(m_tally, w, ti);
      checks++;
      if (winner !== 2'(w) || tie !== ti) begin
        errors++;
        $display("FAIL rand_winner[%0d]: winner=%0d tie=%b, required %0d %b", it, winner, tie, w, ti);
      end
      model_result(s_tally, w, ti);
      checks++;
      if (winner_s !== 2'(w) || tie_s !== ti) begin
        errors++;
        $display("FAIL rand_winner_sat[%0d]: winner=%0d tie=%b, required %0d %b", it, winner_s, tie_s, w, ti);
      end
      if (it % 5 == 4) begin
        c = int'($urandom_range(0, 3));
        read_led(c, lm, ls);
        checks++;
        if (lm !== 8'(m_tally[c]) || ls !== 2'(s_tally[c])) begin
          errors++;
          $display("FAIL rand_led[%0d]: cand=%0d led=%0d led_s=%0d, required %0d %0d", it, c, lm, ls, m_tally[c], s_tally[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_short_press();
    test_multi_press();
    test_winner_tie();
    test_mode_switch();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
